boe_feeder: RTL and testbench

Transmit-side driver for the BOE min/sum/sort engine. It accepts byte frames of 1–6 values from a host over a valid/ready handshake into ping-pong buffers. It then streams each frame into the engine using the engine's `data_num`/`data_in` protocol and sequences the engine's reset between frames. It also emits a tag stream saying which word (min, sum, sorted[k]) the engine's `result` holds in each cycle.

---
 rtl/boe_pkg.sv | 29 ++
 rtl/boe_frame_buf.sv | 61 ++++++
 rtl/boe_feeder.sv | 158 +++++++++++++++
 tb/tb_boe_feeder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boe_pkg.sv
// Shared definitions for the BOE transmit-side feeder.
//   MAX_N       : maximum frame length and engine series depth
//   RK_*        : encodings of the res_kind tag stream
//   bank_e      : occupancy state of one ping-pong bank
//   state_e     : send FSM states
package boe_pkg;

  localparam int MAX_N  = 6;
  localparam int DATA_W = 8;

  localparam logic [1:0] RK_NONE = 2'd0;
  localparam logic [1:0] RK_MIN  = 2'd1;
  localparam logic [1:0] RK_SUM  = 2'd2;
  localparam logic [1:0] RK_SORT = 2'd3;

  typedef enum logic [1:0] {
    B_FREE    = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2
  } bank_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DRAIN = 2'd2,
    S_ERST  = 2'd3
  } state_e;

endpackage

// File: rtl/boe_frame_buf.sv
// One ping-pong bank: up to MAX_N bytes plus a frame length.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : write wr_data into slot cnt (caller only asserts when not full)
//   wr_last   : this write closes the frame
//   free_en   : release a FULL bank back to FREE
//   rd_idx    : combinational read address, rd_data the byte at that slot
//   full      : bank holds a complete frame
//   cnt       : next write slot (bytes written so far in the open frame)
//   len       : length of the closed frame
module boe_frame_buf
  import boe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              free_en,
  input  logic [2:0]        rd_idx,
  output logic              full,
  output logic [2:0]        cnt,
  output logic [2:0]        len,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [MAX_N];
  bank_e             bst;

  // Byte storage is not reset: a cleared FULL flag makes stale bytes unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bst <= B_FREE;
      cnt <= '0;
      len <= '0;
    end else begin
      if (wr_en) begin
        // A sixth byte closes the frame even without wr_last.
        if (wr_last || cnt == 3'(MAX_N - 1)) begin
          bst <= B_FULL;
          len <= cnt + 3'd1;
          cnt <= '0;
        end else begin
          bst <= B_FILLING;
          cnt <= cnt + 3'd1;
        end
      end else if (free_en) begin
        bst <= B_FREE;
      end
    end
  end

  assign full    = (bst == B_FULL);
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/boe_feeder.sv
// Transmit-side driver for the BOE min/sum/sort engine.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : host byte handshake, in_data byte, in_last closes frame
//   eng_rst                  : registered engine reset
//   data_num, data_in        : engine input protocol (length on first beat only)
//   res_kind, res_idx        : tag describing the engine result word this cycle
//   frame_done               : pulse with the last sorted word (ERST cycle)
module boe_feeder
  import boe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       eng_rst,
  output logic [2:0] data_num,
  output logic [7:0] data_in,
  output logic [1:0] res_kind,
  output logic [2:0] res_idx,
  output logic       frame_done
);

  logic              fill_ptr;
  logic              send_ptr;
  logic [1:0]        full;
  logic [2:0]        cnt     [2];
  logic [2:0]        len     [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [2:0]        rd_idx;
  logic              rd_sel;
  logic [2:0]        rd_len;
  logic [DATA_W-1:0] rd_byte;
  logic              accept;
  logic              close;
  logic              free_bank;

  state_e     state;
  logic [2:0] beat;
  logic [2:0] drain;
  logic [2:0] n_cur;

  // Tag for the engine result word that appears one cycle after drain step d.
  function automatic logic [4:0] tag_of(input logic [2:0] d);
    logic [4:0] t;
    t = {RK_NONE, 3'd0};
    if (d == 3'd1)      t = {RK_MIN, 3'd0};
    else if (d == 3'd2) t = {RK_SUM, 3'd0};
    else if (d >= 3'd3) t = {RK_SORT, 3'(d - 3'd3)};
    return t;
  endfunction

  assign in_ready = ~full[fill_ptr];
  assign accept   = in_valid & in_ready;
  assign close    = accept & (in_last | (cnt[fill_ptr] == 3'(MAX_N - 1)));

  // The bank is released on the edge into ERST, so the host sees it free during ERST.
  assign free_bank = (state == S_DRAIN) && (drain == n_cur + 3'd1);

  // In ERST the FSM looks ahead at the other bank to start it without an idle cycle.
  assign rd_sel  = (state == S_ERST) ? ~send_ptr : send_ptr;
  assign rd_idx  = (state == S_SEND && beat < 3'(MAX_N - 1)) ? beat + 3'd1 : 3'd0;
  assign rd_len  = len[rd_sel];
  assign rd_byte = rd_data[rd_sel];

  for (genvar i = 0; i < 2; i++) begin : g_bank
    boe_frame_buf #(.DATA_W(DATA_W)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept && (fill_ptr == 1'(i))),
      .wr_data (in_data),
      .wr_last (in_last),
      .free_en (free_bank && (send_ptr == 1'(i))),
      .rd_idx  (rd_idx),
      .full    (full[i]),
      .cnt     (cnt[i]),
      .len     (len[i]),
      .rd_data (rd_data[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fill_ptr <= 1'b0;
    else if (close) fill_ptr <= ~fill_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      send_ptr   <= 1'b0;
      beat       <= '0;
      drain      <= '0;
      n_cur      <= '0;
      eng_rst    <= 1'b1;
      data_num   <= '0;
      data_in    <= '0;
      res_kind   <= RK_NONE;
      res_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      data_num   <= '0;
      data_in    <= '0;
      res_kind   <= RK_NONE;
      res_idx    <= '0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          eng_rst <= 1'b1;
          if (full[send_ptr]) begin
            state    <= S_SEND;
            beat     <= '0;
            n_cur    <= rd_len;
            eng_rst  <= 1'b0;
            data_num <= rd_len;
            data_in  <= rd_byte;
          end
        end
        S_SEND: begin
          if (beat == n_cur - 3'd1) begin
            state <= S_DRAIN;
            drain <= '0;
          end else begin
            beat    <= beat + 3'd1;
            data_in <= rd_byte;
          end
        end
        S_DRAIN: begin
          if (drain == n_cur + 3'd1) begin
            state      <= S_ERST;
            eng_rst    <= 1'b1;
            res_kind   <= RK_SORT;
            res_idx    <= n_cur - 3'd1;
            frame_done <= 1'b1;
          end else begin
            drain               <= drain + 3'd1;
            {res_kind, res_idx} <= tag_of(drain + 3'd1);
          end
        end
        S_ERST: begin
          send_ptr <= ~send_ptr;
          if (full[~send_ptr]) begin
            state    <= S_SEND;
            beat     <= '0;
            n_cur    <= rd_len;
            eng_rst  <= 1'b0;
            data_num <= rd_len;
            data_in  <= rd_byte;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boe_feeder.sv
// Self-checking bench for boe_feeder: a frame-level model predicts when each
// frame starts and what every output shows relative to that start.
module tb_boe_feeder;
  import boe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       eng_rst;
  logic [2:0] data_num;
  logic [7:0] data_in;
  logic [1:0] res_kind;
  logic [2:0] res_idx;
  logic       frame_done;

  boe_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .eng_rst    (eng_rst),
    .data_num   (data_num),
    .data_in    (data_in),
    .res_kind   (res_kind),
    .res_idx    (res_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct packed {
    logic [5:0][7:0] b;
    int              n;
    int              start;
  } frame_t;

  frame_t          exp_q[$];
  frame_t          cur;
  bit              active = 1'b0;
  int              closes[$];
  int              frees[$];
  int              next_start = 0;
  int              last_start = 0;
  logic [5:0][7:0] acc_b = '0;
  int              acc_n = 0;
  int              total = 0;
  int              bad = 0;

  // A frame closes on in_last or its sixth byte; it starts on the edge after
  // closing, or right after the previous frame's 2n+3 cycle period.
  function automatic void record_accept(input logic [7:0] d, input bit last);
    frame_t f;
    int     ce;
    acc_b[acc_n] = d;
    acc_n++;
    if (last || acc_n == MAX_N) begin
      ce      = cyc + 1;
      f.b     = acc_b;
      f.n     = acc_n;
      f.start = (ce + 1 > next_start) ? ce + 1 : next_start;
      exp_q.push_back(f);
      closes.push_back(ce);
      frees.push_back(f.start + 2 * f.n + 2);
      next_start = f.start + 2 * f.n + 3;
      last_start = f.start;
      acc_n = 0;
      acc_b = '0;
    end
  endfunction

  function automatic void clear_model();
    exp_q.delete();
    closes.delete();
    frees.delete();
    next_start = 0;
    acc_n = 0;
    acc_b = '0;
    active = 1'b0;
  endfunction

  // Monitor: compares every output each cycle against the frame model.
  always @(negedge clk) begin : mon
    int         o;
    int         j;
    int         pend;
    logic       e_rst;
    logic [2:0] e_num;
    logic [7:0] e_din;
    logic [1:0] e_kind;
    logic [2:0] e_idx;
    logic       e_done;
    if (rst) begin
      active = 1'b0;
    end else begin
      if (active && cyc > cur.start + 2 * cur.n + 2) active = 1'b0;
      if (!active && data_num != 3'd0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_frame cyc=%0d data_num=%0d, no frame pending", cyc, data_num);
        end else begin
          cur = exp_q.pop_front();
          active = 1'b1;
          if (cur.start != cyc || cur.n != int'(data_num)) begin
            bad++;
            $display("FAIL frame_start got cyc=%0d n=%0d want cyc=%0d n=%0d",
                     cyc, data_num, cur.start, cur.n);
            cur.start = cyc;
          end
        end
      end
      e_rst = 1'b1; e_num = 3'd0; e_din = 8'd0;
      e_kind = RK_NONE; e_idx = 3'd0; e_done = 1'b0;
      if (active) begin
        o = cyc - cur.start;
        e_rst = (o == 2 * cur.n + 2);
        if (o < cur.n) begin
          e_din = cur.b[o];
          if (o == 0) e_num = 3'(cur.n);
        end
        if (o >= cur.n + 1 && o <= 2 * cur.n + 2) begin
          j = o - cur.n - 1;
          e_kind = (j == 0) ? RK_MIN : (j == 1) ? RK_SUM : RK_SORT;
          e_idx  = (j >= 2) ? 3'(j - 2) : 3'd0;
          e_done = (o == 2 * cur.n + 2);
        end
      end
      total++;
      if ({eng_rst, data_num, data_in, res_kind, res_idx, frame_done} !==
          {e_rst, e_num, e_din, e_kind, e_idx, e_done}) begin
        bad++;
        $display("FAIL outputs cyc=%0d got rst=%0d num=%0d din=%0d kind=%0d idx=%0d done=%0d want rst=%0d num=%0d din=%0d kind=%0d idx=%0d done=%0d",
                 cyc, eng_rst, data_num, data_in, res_kind, res_idx, frame_done,
                 e_rst, e_num, e_din, e_kind, e_idx, e_done);
      end
      while (frees.size() > 0 && frees[0] <= cyc) begin
        void'(frees.pop_front());
        void'(closes.pop_front());
      end
      pend = 0;
      for (int i = 0; i < closes.size(); i++)
        if (closes[i] <= cyc && frees[i] > cyc) pend++;
      total++;
      if (in_ready !== (pend < 2)) begin
        bad++;
        $display("FAIL in_ready cyc=%0d got %0d want %0d", cyc, in_ready, (pend < 2));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic put(input logic [7:0] d, input bit last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL put_timeout in_ready stuck at 0, want 1 within 300 cycles");
    end else begin
      record_accept(d, last);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [5:0][7:0] b);
    for (int i = 0; i < n; i++) put(b[i], i == n - 1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || active || cyc < next_start) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 1000) begin
      bad++;
      $display("FAIL wait_idle pending=%0d active=%0d, want drained within 1000 cycles",
               exp_q.size(), active);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0][7:0] fb;
    int              n;
    int              seen;
    bit              lst;

    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, eng_rst, data_num, data_in, res_kind, res_idx, frame_done} !==
        {1'b1, 1'b1, 3'd0, 8'd0, 2'd0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got rdy=%0d rst=%0d num=%0d din=%0d kind=%0d idx=%0d done=%0d want 1 1 0 0 0 0 0",
               in_ready, eng_rst, data_num, data_in, res_kind, res_idx, frame_done);
    end
    rst = 1'b0;
    @(negedge clk);

    // {5,9,2}
    fb = '0; fb[0] = 8'd5; fb[1] = 8'd9; fb[2] = 8'd2;
    send_frame(3, fb);
    wait_idle();

    // {7} then {3,4} back to back
    fb = '0; fb[0] = 8'd7;
    send_frame(1, fb);
    fb = '0; fb[0] = 8'd3; fb[1] = 8'd4;
    send_frame(2, fb);
    wait_idle();

    // seven bytes without in_last; the sixth force-closes the first frame
    for (int i = 0; i < 6; i++) put(8'(10 + i), 1'b0);
    put(8'd77, 1'b1);
    wait_idle();

    // pre-fill both banks, then a third frame must wait for ERST
    fb = '0; fb[0] = 8'd1; fb[1] = 8'd2; fb[2] = 8'd3; fb[3] = 8'd4;
    send_frame(4, fb);
    fb = '0; fb[0] = 8'd200; fb[1] = 8'd100; fb[2] = 8'd150;
    send_frame(3, fb);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL prefill_block in_ready got %0d want 0", in_ready);
    end
    fb = '0; fb[0] = 8'd42; fb[1] = 8'd43;
    send_frame(2, fb);
    wait_idle();

    // idle gap then a single frame starts one cycle after its close
    repeat (4) @(negedge clk);
    fb = '0; fb[0] = 8'd255; fb[1] = 8'd0;
    send_frame(2, fb);
    wait_idle();

    // randomized frames, lengths 1..7 (7 forces a close at six), random gaps
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        lst = (i == n - 1) && !(n == 6 && $urandom_range(0, 1) == 1);
        if (n == 7 && i == 6) lst = 1'b1;
        put(8'($urandom_range(0, 255)), lst);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (n == 6 && acc_n != 0) put(8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_idle();

    // reset in the middle of DRAIN
    fb = '0; fb[0] = 8'd8; fb[1] = 8'd6; fb[2] = 8'd7;
    send_frame(3, fb);
    while (cyc < last_start + 4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({in_ready, eng_rst, data_num, data_in, res_kind, res_idx, frame_done} !==
        {1'b1, 1'b1, 3'd0, 8'd0, 2'd0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_values got rdy=%0d rst=%0d num=%0d din=%0d kind=%0d idx=%0d done=%0d want 1 1 0 0 0 0 0",
               in_ready, eng_rst, data_num, data_in, res_kind, res_idx, frame_done);
    end
    @(negedge clk);
    clear_model();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (frame_done) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_done frame_done pulses got %0d want 0", seen);
    end

    // after reset the feeder must still work
    fb = '0; fb[0] = 8'd11; fb[1] = 8'd22;
    send_frame(2, fb);
    wait_idle();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_frames got %0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
